// File: rtl/seq_detector_param.sv
// Serial pattern detector: samples `in` once per divided tick and flags a registered hit when
// the last PAT_W samples equal a runtime-loadable pattern. Optional hit counter: SEQ_DET_HIT_CNT_EN.
module seq_detector_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      DIV     = 25000000,
  parameter int unsigned      OVERLAP = 1,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             hit,
  output logic [4:0]       led
`ifdef SEQ_DET_HIT_CNT_EN
  ,
  output logic [7:0]       hit_cnt
`endif
);

  localparam int unsigned DW    = $clog2(DIV + 1);
  localparam int unsigned FW    = $clog2(PAT_W + 1);
  localparam int unsigned LED_W = 5;

  typedef enum logic {
    S_FILLING = 1'b0,
    S_ARMED   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic [PAT_W-1:0]   window_q, window_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               hit_q, hit_d;
  logic [LED_W-1:0]   led_q, led_d;

  logic               tick_c;
  logic               adv_c;
  logic               full_c;
  logic               match_c;
  logic [PAT_W-1:0]   win_n_c;
  logic [FW-1:0]      fill_n_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILLING;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: armed once PAT_W samples are in; non-overlap mode disarms on every hit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILLING: begin
        if (adv_c && (fill_q == FW'(PAT_W - 1)) && !(match_c && (OVERLAP == 0))) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (pat_load) begin
          state_d = S_FILLING;
        end else if (match_c && (OVERLAP == 0)) begin
          state_d = S_FILLING;
        end
      end
      default: state_d = S_FILLING;
    endcase
  end

  // Outputs of the FSM: sample advance, shifted window and match decision
  always_comb begin
    tick_c   = (div_cnt_q == DW'(DIV - 1));
    adv_c    = tick_c && !pat_load;
    win_n_c  = {window_q[PAT_W-2:0], in};
    full_c   = (state_q == S_ARMED) || (fill_q == FW'(PAT_W - 1));
    fill_n_c = (state_q == S_ARMED) ? FW'(PAT_W) : fill_q + FW'(1);
    match_c  = adv_c && full_c && (win_n_c == pat_q);
  end

  // Datapath next values; a load discards the coincident sample
  always_comb begin
    div_cnt_d = tick_c ? '0 : div_cnt_q + DW'(1);
    pat_d     = pat_q;
    window_d  = window_q;
    fill_d    = fill_q;
    hit_d     = 1'b0;
    led_d     = led_q;
    if (pat_load) begin
      pat_d    = pat_in;
      window_d = '0;
      fill_d   = '0;
      led_d    = '0;
    end else if (tick_c) begin
      window_d = win_n_c;
      hit_d    = match_c;
      led_d    = {match_c, win_n_c[3:0]};
      fill_d   = (match_c && (OVERLAP == 0)) ? '0 : fill_n_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      pat_q     <= PAT_RST;
      window_q  <= '0;
      fill_q    <= '0;
      hit_q     <= 1'b0;
      led_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pat_q     <= pat_d;
      window_q  <= window_d;
      fill_q    <= fill_d;
      hit_q     <= hit_d;
      led_q     <= led_d;
    end
  end

  assign hit = hit_q;
  assign led = led_q;

`ifdef SEQ_DET_HIT_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating hit counter, advanced on the same edge that raises hit
  always_comb begin
    cnt_d = cnt_q;
    if (pat_load) begin
      cnt_d = '0;
    end else if (match_c && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_cnt = cnt_q;
`endif

endmodule
